// File: rtl/conc_trace_recorder.sv
// Run-length compressing response recorder: samples {resp, stim} each enabled
// clock, folds identical consecutive samples into one record and queues records in a FWFT FIFO.
module conc_trace_recorder #(
    parameter int DEPTH = 16,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             capture_en,
    input  logic [11:0]      stim,
    input  logic [5:0]       resp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [21:0]      out_data,
    output logic [LVL_W-1:0] level,
    output logic             overflow,
    output logic [7:0]       drop_count,
    input  logic             clear_ovf
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             run_valid;
    logic [17:0]      run_data;
    logic [3:0]       run_cnt;
    logic [17:0]      sample;
    logic [21:0]      rec;
    logic             push, pop, full, wr_en, drop;
    logic [21:0]      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic [LVL_W-1:0] remain;
    logic [21:0]      head_nxt;

    assign sample    = {resp, stim};
    assign rec       = {run_cnt, run_data};
    assign out_valid = (level != '0);

    // A run closes when the sample changes, the counter saturates, or capture stops.
    always_comb begin
        push  = capture_en ? (run_valid && (sample != run_data || run_cnt == 4'd15))
                           : run_valid;
        pop   = out_valid && out_ready;
        full  = (level == LVL_W'(DEPTH));
        wr_en = push && (!full || pop);
        drop  = push && full && !pop;
    end

    // out_data is registered, so precompute the head that will be exposed after this edge.
    always_comb begin
        rd_nxt   = rd_ptr + PTR_W'(pop);
        remain   = level - LVL_W'(pop);
        head_nxt = out_data;
        if (remain != '0)
            head_nxt = mem[rd_nxt];
        else if (wr_en)
            head_nxt = rec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_valid <= 1'b0;
            run_data  <= '0;
            run_cnt   <= '0;
        end else if (capture_en) begin
            run_valid <= 1'b1;
            if (run_valid && sample == run_data && run_cnt != 4'd15) begin
                run_cnt <= run_cnt + 4'd1;
            end else begin
                run_data <= sample;
                run_cnt  <= '0;
            end
        end else begin
            run_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= rec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            out_data <= '0;
        end else begin
            rd_ptr   <= rd_nxt;
            wr_ptr   <= wr_ptr + PTR_W'(wr_en);
            level    <= level + LVL_W'(wr_en) - LVL_W'(pop);
            out_data <= head_nxt;
        end
    end

    // A drop on the same edge as clear_ovf leaves a count of one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow   <= 1'b1;
            if (clear_ovf)
                drop_count <= 8'd1;
            else if (drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end else if (clear_ovf) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end
endmodule

// File: tb/tb_conc_trace_recorder.sv
// Scoreboard bench for conc_trace_recorder: a queue-based reference model predicts
// every record, level and overflow state; a negedge monitor compares against the DUT.
module tb_conc_trace_recorder;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        capture_en = 1'b0;
    logic [11:0] stim = '0;
    logic [5:0]  resp = '0;
    logic        out_ready = 1'b0;
    logic        clear_ovf = 1'b0;
    logic        out_valid;
    logic [21:0] out_data;
    logic [4:0]  level;
    logic        overflow;
    logic [7:0]  drop_count;

    int vectors = 0;
    int miscompares = 0;

    conc_trace_recorder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .capture_en(capture_en), .stim(stim), .resp(resp),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .overflow(overflow), .drop_count(drop_count), .clear_ovf(clear_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: current run plus a bounded queue of finished records.
    bit          m_rv = 1'b0;
    logic [17:0] m_rd = '0;
    int          m_rc = 0;
    logic [21:0] m_q[$];
    bit          m_ovf = 1'b0;
    int          m_drop = 0;

    logic [17:0] smp;
    logic [21:0] new_rec;
    bit          do_push, dropped;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_rv = 1'b0; m_rc = 0; m_rd = '0; m_q.delete(); m_ovf = 1'b0; m_drop = 0;
        end else begin
            chk("out_valid", out_valid, m_q.size() > 0);
            chk("level", level, m_q.size());
            chk("overflow", overflow, m_ovf);
            chk("drop_count", drop_count, m_drop);
            if (m_q.size() > 0) chk("out_data", out_data, m_q[0]);
            smp = {resp, stim};
            do_push = 1'b0;
            new_rec = '0;
            if (capture_en) begin
                if (!m_rv) begin
                    m_rv = 1'b1; m_rd = smp; m_rc = 0;
                end else if (smp == m_rd && m_rc < 15) begin
                    m_rc++;
                end else begin
                    do_push = 1'b1; new_rec = {4'(m_rc), m_rd}; m_rd = smp; m_rc = 0;
                end
            end else if (m_rv) begin
                do_push = 1'b1; new_rec = {4'(m_rc), m_rd}; m_rv = 1'b0;
            end
            if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
            dropped = 1'b0;
            if (do_push) begin
                if (m_q.size() < DEPTH) m_q.push_back(new_rec);
                else dropped = 1'b1;
            end
            if (clear_ovf) begin m_ovf = 1'b0; m_drop = 0; end
            if (dropped) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
    end

    task automatic drv(input bit en, input logic [11:0] s, input logic [5:0] r,
                       input bit rdy, input bit clr);
        @(posedge clk);
        #1;
        capture_en = en; stim = s; resp = r; out_ready = rdy; clear_ovf = clr;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_out_data", out_data, 0);
        capture_en = 1'b0; out_ready = 1'b0; clear_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        repeat (n) drv(1'b0, 12'h0, 6'h0, 1'b1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] base;
        do_reset();

        // Run compression
        repeat (20) drv(1'b1, 12'h123, 6'h05, 1'b0, 1'b0);
        drv(1'b0, 12'h0, 6'h0, 1'b0, 1'b0);
        drv(1'b0, 12'h0, 6'h0, 1'b0, 1'b0);
        chk("runs_level", level, 2);
        chk("runs_head", out_data, 22'h3C5123);
        chk("runs_ovf", overflow, 0);
        drv(1'b0, 12'h0, 6'h0, 1'b1, 1'b0);
        drv(1'b0, 12'h0, 6'h0, 1'b0, 1'b0);
        chk("runs_second", out_data, 22'h0C5123);
        drain(3);
        chk("runs_empty", level, 0);

        // Alternation
        for (int i = 0; i < 8; i++) drv(1'b1, (i % 2) ? 12'hFFF : 12'h000, 6'h0, 1'b0, 1'b0);
        drv(1'b0, 12'h0, 6'h0, 1'b0, 1'b0);
        drv(1'b0, 12'h0, 6'h0, 1'b0, 1'b0);
        chk("alt_level", level, 8);
        chk("alt_head", out_data, 22'h000000);
        drv(1'b0, 12'h0, 6'h0, 1'b1, 1'b0);
        drv(1'b0, 12'h0, 6'h0, 1'b0, 1'b0);
        chk("alt_second", out_data, 22'h000FFF);
        drain(10);

        // Overflow, backpressure, clear
        do_reset();
        for (int i = 0; i < 20; i++) drv(1'b1, 12'(i), 6'h0, 1'b0, 1'b0);
        drv(1'b0, 12'h0, 6'h0, 1'b0, 1'b0);
        drv(1'b0, 12'h0, 6'h0, 1'b0, 1'b0);
        chk("ovf_level", level, 16);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drops", drop_count, 4);
        chk("ovf_head", out_data, 22'h0);
        repeat (5) begin
            drv(1'b0, 12'h0, 6'h0, 1'b0, 1'b0);
            chk("bp_hold", out_data, 22'h0);
        end
        drv(1'b0, 12'h0, 6'h0, 1'b0, 1'b1);
        drv(1'b0, 12'h0, 6'h0, 1'b0, 1'b0);
        chk("clr_flag", overflow, 0);
        chk("clr_drops", drop_count, 0);
        drv(1'b1, 12'h200, 6'h0, 1'b0, 1'b0);
        drv(1'b1, 12'h201, 6'h0, 1'b0, 1'b1);
        drv(1'b0, 12'h0, 6'h0, 1'b0, 1'b0);
        chk("clr_vs_drop_flag", overflow, 1);
        chk("clr_vs_drop_cnt", drop_count, 1);
        drain(20);

        // Full with simultaneous pop
        do_reset();
        base = 12'($urandom_range(0, 255)) << 4;
        for (int i = 0; i < 17; i++) drv(1'b1, base + 12'(i), 6'h0, 1'b0, 1'b0);
        drv(1'b1, 12'hFFF, 6'h3F, 1'b1, 1'b0);
        drv(1'b0, 12'h0, 6'h0, 1'b1, 1'b0);
        chk("fullpop_level", level, 16);
        chk("fullpop_ovf", overflow, 0);
        drv(1'b0, 12'h0, 6'h0, 1'b0, 1'b0);
        chk("fullpop_level2", level, 16);
        chk("fullpop_drops", drop_count, 0);
        drain(20);

        // Reset mid-run
        for (int i = 0; i < 4; i++) drv(1'b1, 12'h300 + 12'(i), 6'h2, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("pre_reset_level", level, 3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_level", level, 0);
        capture_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) drv(1'b1, 12'hAAA, 6'h11, 1'b0, 1'b0);
        drv(1'b0, 12'h0, 6'h0, 1'b0, 1'b0);
        drv(1'b0, 12'h0, 6'h0, 1'b0, 1'b0);
        chk("post_reset_level", level, 1);
        chk("post_reset_rec", out_data, {4'd2, 6'h11, 12'hAAA});
        drain(3);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            drv($urandom_range(0, 9) != 0,
                ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 2)),
                6'($urandom_range(0, 1)),
                (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                $urandom_range(0, 30) == 0);
        end
        drain(25);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
